// File: rtl/axi_perf_pkg.sv
// -----------------------------------------------------------------------------
// axi_perf_pkg
//   Shared AXI encodings and the write-generator state type used by the
//   axi_perf traffic generators.
// -----------------------------------------------------------------------------
package axi_perf_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } wr_gen_state_t;

endpackage

// File: rtl/svc_sync_fifo.sv
// -----------------------------------------------------------------------------
// svc_sync_fifo
//   Single-clock show-ahead FIFO.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     push, din       write request and data (ignored when full)
//     pop             read request (ignored when empty)
//     dout            head-of-queue data, valid while !empty
//     full, empty     occupancy flags
// -----------------------------------------------------------------------------
module svc_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_perf_wr_gen.sv
// -----------------------------------------------------------------------------
// axi_perf_wr_gen
//   AXI4 write-traffic generator. Issues burst_count INCR bursts of
//   burst_len+1 beats starting at base_addr; every 32-bit lane of each beat
//   carries the global beat index. Reports run length in cycles, the number
//   of non-OKAY write responses and (optionally) worst AW->B latency.
//
//   Ports:
//     clk, rst_n                    MIG UI clock, asynchronous active-low reset
//     start                         one-cycle run request, honoured in idle only
//     base_addr/burst_len/          run configuration, latched on start
//       burst_count
//     busy, done                    run in progress / one-cycle end pulse
//     cycles, errors, max_latency   run statistics
//     m_axi_aw*, m_axi_w*, m_axi_b* AXI4 write master channels
//
//   Build option: define AXI_PERF_WR_GEN_LATENCY_EN to enable per-burst
//   latency tracking via a timestamp FIFO; otherwise max_latency is 0.
// -----------------------------------------------------------------------------
module axi_perf_wr_gen
    import axi_perf_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH  = 28,
    parameter int unsigned AXI_DATA_WIDTH  = 128,
    parameter int unsigned AXI_ID_WIDTH    = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [AXI_ADDR_WIDTH-1:0]   base_addr,
    input  logic [7:0]                  burst_len,
    input  logic [15:0]                 burst_count,
    output logic                        busy,
    output logic                        done,
    output logic [31:0]                 cycles,
    output logic [15:0]                 errors,
    output logic [15:0]                 max_latency,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
    output logic [7:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wlast,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]                  m_axi_bresp
);

    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
    localparam int unsigned SIZE   = $clog2(STRB_W);
    localparam int unsigned LANES  = AXI_DATA_WIDTH / 32;

    wr_gen_state_t state, state_next;

    logic [15:0]               cfg_count;
    logic [AXI_ADDR_WIDTH-1:0] stride;
    logic [15:0]               aw_sent, b_recv, w_bursts;
    logic [15:0]               aw_sent_n, b_recv_n, w_bursts_n, outstanding_n;
    logic [7:0]                w_beat;
    logic [31:0]               beat_idx;
    logic                      aw_valid, w_valid;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic [STRB_W-1:0]         w_strb;
    logic [31:0]               cycles_q;
    logic [15:0]               errors_q;
    logic                      aw_fire, w_fire, b_fire, w_last;
    logic                      aw_more, w_more;
    logic                      unused_bid;

    assign unused_bid = ^m_axi_bid;

    // Handshakes and post-cycle counter values. Next valids are computed from
    // these so they stay registered while still allowing back-to-back issue.
    assign aw_fire       = aw_valid && m_axi_awready;
    assign w_fire        = w_valid && m_axi_wready;
    assign b_fire        = m_axi_bready && m_axi_bvalid;
    assign w_last        = w_valid && (w_beat == aw_len);
    assign aw_sent_n     = aw_sent + 16'(aw_fire);
    assign b_recv_n      = b_recv + 16'(b_fire);
    assign w_bursts_n    = w_bursts + 16'(w_fire && w_last);
    assign outstanding_n = aw_sent_n - b_recv_n;
    assign aw_more       = (aw_sent_n < cfg_count) &&
                           ({1'b0, outstanding_n} < 17'(MAX_OUTSTANDING));
    assign w_more        = (w_bursts_n < aw_sent_n);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (burst_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (b_fire && (b_recv_n == cfg_count)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        m_axi_bready = 1'b0;
        case (state)
            RUN: begin
                busy         = 1'b1;
                m_axi_bready = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_count <= '0;
            stride    <= '0;
            aw_sent   <= '0;
            b_recv    <= '0;
            w_bursts  <= '0;
            w_beat    <= '0;
            beat_idx  <= '0;
            aw_valid  <= 1'b0;
            w_valid   <= 1'b0;
            aw_addr   <= '0;
            aw_id     <= '0;
            aw_len    <= '0;
            aw_size   <= '0;
            aw_burst  <= '0;
            w_strb    <= '0;
            cycles_q  <= '0;
            errors_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cfg_count <= burst_count;
                        stride    <= (AXI_ADDR_WIDTH'(burst_len) + AXI_ADDR_WIDTH'(1)) << SIZE;
                        aw_addr   <= base_addr & ~AXI_ADDR_WIDTH'(STRB_W - 1);
                        aw_id     <= '0;
                        aw_len    <= burst_len;
                        aw_size   <= 3'(SIZE);
                        aw_burst  <= AXI_BURST_INCR;
                        w_strb    <= '1;
                        aw_sent   <= '0;
                        b_recv    <= '0;
                        w_bursts  <= '0;
                        w_beat    <= '0;
                        beat_idx  <= '0;
                        aw_valid  <= (burst_count != '0);
                        w_valid   <= 1'b0;
                        cycles_q  <= '0;
                        errors_q  <= '0;
                    end
                end
                RUN: begin
                    aw_sent  <= aw_sent_n;
                    b_recv   <= b_recv_n;
                    w_bursts <= w_bursts_n;
                    if (aw_fire) begin
                        aw_addr <= aw_addr + stride;
                        aw_id   <= AXI_ID_WIDTH'(aw_sent_n);
                    end
                    aw_valid <= (aw_valid && !aw_fire) || aw_more;
                    if (w_fire) begin
                        beat_idx <= beat_idx + 1'b1;
                        w_beat   <= w_last ? '0 : w_beat + 1'b1;
                    end
                    w_valid <= (w_valid && !w_fire) || w_more;
                    if (b_fire && (m_axi_bresp != AXI_RESP_OKAY) && (errors_q != 16'hFFFF)) begin
                        errors_q <= errors_q + 1'b1;
                    end
                    if (cycles_q != 32'hFFFF_FFFF) begin
                        cycles_q <= cycles_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_axi_awvalid = aw_valid;
    assign m_axi_awaddr  = aw_addr;
    assign m_axi_awid    = aw_id;
    assign m_axi_awlen   = aw_len;
    assign m_axi_awsize  = aw_size;
    assign m_axi_awburst = aw_burst;
    assign m_axi_wvalid  = w_valid;
    assign m_axi_wdata   = {LANES{beat_idx}};
    assign m_axi_wstrb   = w_strb;
    assign m_axi_wlast   = w_last;
    assign cycles        = cycles_q;
    assign errors        = errors_q;

`ifdef AXI_PERF_WR_GEN_LATENCY_EN
    logic [31:0] now;
    logic [31:0] ts_head;
    logic [31:0] lat;
    logic [15:0] lat_sat;
    logic [15:0] max_lat_q;
    logic        ts_full, ts_empty;

    // Responses return in order, so the FIFO head is the timestamp of the
    // burst whose B is being accepted.
    svc_sync_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_ts_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (aw_fire && !ts_full),
        .din   (now),
        .pop   (b_fire && !ts_empty),
        .dout  (ts_head),
        .full  (ts_full),
        .empty (ts_empty)
    );

    assign lat     = now - ts_head;
    assign lat_sat = (lat > 32'h0000_FFFF) ? 16'hFFFF : lat[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now       <= '0;
            max_lat_q <= '0;
        end else begin
            now <= now + 1'b1;
            if ((state == IDLE) && start) begin
                max_lat_q <= '0;
            end else if (b_fire && !ts_empty && (lat_sat > max_lat_q)) begin
                max_lat_q <= lat_sat;
            end
        end
    end

    assign max_latency = max_lat_q;
`else
    assign max_latency = '0;
`endif

endmodule

// File: tb/tb_axi_perf_wr_gen.sv
module tb_axi_perf_wr_gen;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam int IW = 4;
    localparam int MO = 4;
    localparam int SB = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [7:0]    burst_len = '0;
    logic [15:0]   burst_count = '0;
    logic          busy, done;
    logic [31:0]   cycles;
    logic [15:0]   errors, max_latency;
    logic          awvalid, awready;
    logic [AW-1:0] awaddr;
    logic [IW-1:0] awid;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          wvalid, wready, wlast;
    logic [DW-1:0] wdata;
    logic [SB-1:0] wstrb;
    logic          bvalid, bready;
    logic [IW-1:0] bid;
    logic [1:0]    bresp;

    always #5 clk = ~clk;

    axi_perf_wr_gen #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .AXI_ID_WIDTH   (IW),
        .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .burst_len(burst_len), .burst_count(burst_count), .busy(busy), .done(done),
        .cycles(cycles), .errors(errors), .max_latency(max_latency),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
        .m_axi_awid(awid), .m_axi_awlen(awlen), .m_axi_awsize(awsize), .m_axi_awburst(awburst),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata),
        .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bid(bid), .m_axi_bresp(bresp)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
    } aw_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SB-1:0] strb;
        logic          last;
    } w_t;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;

    // slave / monitor state
    aw_t aw_log[$];
    w_t  w_log[$];
    int  bq[$];
    int  aw_cnt, b_cnt, w_burst_cnt, order_viol, stab_viol, awv_seen, wv_seen, max_out;
    int  last_b_edge, aw_at_first_b, s_edge;
    bit  aw_rand, w_rand, b_en, b_rand, b_active;
    int  err_idx;
    bit  p_aw_stall, p_w_stall;
    aw_t p_aw;
    w_t  p_w;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference model: burst k address and beat j payload from the rules.
    function automatic aw_t exp_aw(input logic [AW-1:0] b, input int l, input int k);
        aw_t e;
        e.addr  = (b & ~AW'(SB - 1)) + AW'(k * (l + 1) * SB);
        e.id    = IW'(k);
        e.len   = 8'(l);
        e.size  = 3'($clog2(SB));
        e.burst = 2'b01;
        return e;
    endfunction

    function automatic w_t exp_w(input int l, input int j);
        w_t e;
        e.data = {(DW/32){32'(j)}};
        e.strb = '1;
        e.last = ((j % (l + 1)) == l);
        return e;
    endfunction

    // AXI slave and protocol monitor
    initial begin
        aw_t cur_aw;
        w_t  cur_w;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                cur_aw = {awaddr, awid, awlen, awsize, awburst};
                cur_w  = {wdata, wstrb, wlast};
                if (p_aw_stall && (!awvalid || cur_aw !== p_aw)) stab_viol++;
                if (p_w_stall && (!wvalid || cur_w !== p_w)) stab_viol++;
                if (awvalid) awv_seen++;
                if (wvalid) wv_seen++;
                if (wvalid && wready) begin
                    if (w_burst_cnt >= aw_cnt) order_viol++;
                    w_log.push_back(cur_w);
                    if (wlast) begin
                        bq.push_back(w_burst_cnt);
                        w_burst_cnt++;
                    end
                end
                if (awvalid && awready) begin
                    aw_log.push_back(cur_aw);
                    aw_cnt++;
                end
                if (bvalid && bready) begin
                    if (b_cnt == 0) aw_at_first_b = aw_cnt;
                    b_cnt++;
                    last_b_edge = edge_cnt + 1;
                    b_active = 1'b0;
                end
                if (aw_cnt - b_cnt > max_out) max_out = aw_cnt - b_cnt;
                p_aw_stall = awvalid && !awready;
                p_w_stall  = wvalid && !wready;
                p_aw = cur_aw;
                p_w  = cur_w;
            end else begin
                p_aw_stall = 1'b0;
                p_w_stall  = 1'b0;
            end
            @(posedge clk);
            #1;
            awready = aw_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            wready  = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!b_active && b_en && bq.size() > 0 && (!b_rand || $urandom_range(0, 1) == 1)) begin
                int idx;
                idx = bq.pop_front();
                b_active = 1'b1;
                bid   = IW'(idx);
                bresp = (idx == err_idx) ? 2'b10 : 2'b00;
            end
            bvalid = b_active;
        end
    end

    task automatic slave_clear();
        aw_log.delete(); w_log.delete(); bq.delete();
        aw_cnt = 0; b_cnt = 0; w_burst_cnt = 0; order_viol = 0; stab_viol = 0;
        awv_seen = 0; wv_seen = 0; max_out = 0; last_b_edge = -1; aw_at_first_b = -1;
        p_aw_stall = 1'b0; p_w_stall = 1'b0; b_active = 1'b0; bvalid = 1'b0;
    endtask

    task automatic set_modes(input bit ar, input bit wr, input bit be, input bit br, input int ei);
        aw_rand = ar; w_rand = wr; b_en = be; b_rand = br; err_idx = ei;
    endtask

    task automatic start_run(input logic [AW-1:0] b, input int l, input int c);
        slave_clear();
        base_addr = b; burst_len = 8'(l); burst_count = 16'(c);
        @(posedge clk); #1;
        start = 1'b1;
        s_edge = edge_cnt + 1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit found, output int d_edge);
        found = 1'b0;
        d_edge = -1;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1'b1;
                d_edge = edge_cnt;
            end
        end
    endtask

    task automatic test_reset();
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, done, awvalid, wvalid, bready} !== 5'b0) begin
            n_errors++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, awvalid, wvalid, bready});
        end
        n_checks++;
        if ({cycles, errors, max_latency} !== '0) begin
            n_errors++; $display("FAIL reset_counters: got %0h/%0h/%0h expected 0", cycles, errors, max_latency);
        end
        n_checks++;
        if ({awaddr, awid, awlen, awsize, awburst, wdata, wstrb, wlast} !== '0) begin
            n_errors++; $display("FAIL reset_payload: got addr %0h data %0h expected 0", awaddr, wdata);
        end
    endtask

    task automatic test_basic();
        bit found; int d;
        set_modes(0, 0, 1, 0, -1);
        start_run(28'h100, 3, 2);
        n_checks++;
        if ({busy, awvalid} !== 2'b11) begin
            n_errors++; $display("FAIL basic_start_latency: got busy/awvalid %b expected 11", {busy, awvalid});
        end
        wait_done(200, found, d);
        n_checks++;
        if (!found) begin n_errors++; $display("FAIL basic_done_timeout: got none expected done"); end
        n_checks++;
        if (d !== last_b_edge) begin n_errors++; $display("FAIL basic_done_edge: got %0d expected %0d", d, last_b_edge); end
        n_checks++;
        if (busy !== 1'b0 || errors !== 16'd0) begin
            n_errors++; $display("FAIL basic_end_state: got busy %b errors %0d expected 0 0", busy, errors);
        end
        n_checks++;
        if (cycles !== 32'(last_b_edge - s_edge)) begin
            n_errors++; $display("FAIL basic_cycles: got %0d expected %0d", cycles, last_b_edge - s_edge);
        end
        n_checks++;
        if (aw_log.size() !== 2 || w_log.size() !== 8) begin
            n_errors++; $display("FAIL basic_counts: got %0d aw %0d w expected 2 8", aw_log.size(), w_log.size());
        end
        for (int k = 0; k < 2 && k < aw_log.size(); k++) begin
            n_checks++;
            if (aw_log[k] !== exp_aw(28'h100, 3, k)) begin
                n_errors++; $display("FAIL basic_aw%0d: got %0h expected %0h", k, aw_log[k], exp_aw(28'h100, 3, k));
            end
        end
        for (int j = 0; j < 8 && j < w_log.size(); j++) begin
            n_checks++;
            if (w_log[j] !== exp_w(3, j)) begin
                n_errors++; $display("FAIL basic_w%0d: got %0h expected %0h", j, w_log[j], exp_w(3, j));
            end
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin n_errors++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_outstanding();
        bit found; int d;
        set_modes(0, 0, 0, 0, -1);
        start_run(AW'($urandom), 1, 8);
        repeat (30) @(negedge clk);
        n_checks++;
        if (aw_cnt !== MO || awvalid !== 1'b0) begin
            n_errors++; $display("FAIL outstanding_stall: got %0d aw awvalid %b expected %0d 0", aw_cnt, awvalid, MO);
        end
        b_en = 1'b1;
        wait_done(500, found, d);
        n_checks++;
        if (!found || aw_at_first_b !== MO) begin
            n_errors++; $display("FAIL outstanding_first_b: got done %b aw %0d expected 1 %0d", found, aw_at_first_b, MO);
        end
        n_checks++;
        if (aw_cnt !== 8 || max_out !== MO || errors !== 16'd0) begin
            n_errors++; $display("FAIL outstanding_end: got aw %0d max %0d err %0d expected 8 %0d 0", aw_cnt, max_out, errors, MO);
        end
    endtask

    task automatic test_random_ready();
        bit found; int d; logic [AW-1:0] b;
        set_modes(1, 1, 1, 1, -1);
        b = AW'($urandom);
        start_run(b, 0, 12);
        wait_done(2000, found, d);
        n_checks++;
        if (!found || order_viol !== 0 || stab_viol !== 0) begin
            n_errors++; $display("FAIL random_ready_protocol: got done %b order %0d stab %0d expected 1 0 0", found, order_viol, stab_viol);
        end
        n_checks++;
        if (aw_log.size() !== 12 || w_log.size() !== 12) begin
            n_errors++; $display("FAIL random_ready_counts: got %0d %0d expected 12 12", aw_log.size(), w_log.size());
        end
        for (int k = 0; k < 12 && k < aw_log.size() && k < w_log.size(); k++) begin
            n_checks++;
            if (aw_log[k] !== exp_aw(b, 0, k) || w_log[k] !== exp_w(0, k)) begin
                n_errors++; $display("FAIL random_ready_beat%0d: got %0h/%0h expected %0h/%0h", k, aw_log[k], w_log[k], exp_aw(b, 0, k), exp_w(0, k));
            end
        end
        n_checks++;
        if (cycles !== 32'(last_b_edge - s_edge)) begin
            n_errors++; $display("FAIL random_ready_cycles: got %0d expected %0d", cycles, last_b_edge - s_edge);
        end
    endtask

    task automatic test_slverr();
        bit found; int d;
        set_modes(0, 0, 1, 0, 1);
        start_run(AW'($urandom), $urandom_range(0, 7), 3);
        wait_done(500, found, d);
        n_checks++;
        if (!found || errors !== 16'd1 || b_cnt !== 3) begin
            n_errors++; $display("FAIL slverr_count: got done %b errors %0d b %0d expected 1 1 3", found, errors, b_cnt);
        end
    endtask

    task automatic test_zero_count();
        bit found; int d;
        set_modes(0, 0, 1, 0, -1);
        start_run(28'h40, 5, 0);
        wait_done(5, found, d);
        n_checks++;
        if (!found || d !== s_edge) begin
            n_errors++; $display("FAIL zero_done_edge: got %0d expected %0d", d, s_edge);
        end
        n_checks++;
        if (cycles !== 32'd0 || busy !== 1'b0) begin
            n_errors++; $display("FAIL zero_cycles: got %0d busy %b expected 0 0", cycles, busy);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (awv_seen !== 0 || wv_seen !== 0 || b_cnt !== 0) begin
            n_errors++; $display("FAIL zero_no_valid: got aw %0d w %0d b %0d expected 0 0 0", awv_seen, wv_seen, b_cnt);
        end
    endtask

    task automatic test_reset_midrun();
        bit found; int d; logic [AW-1:0] b;
        set_modes(0, 0, 1, 1, 2);
        start_run(AW'($urandom), 7, 20);
        repeat (15) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, awvalid, wvalid, bready, wlast} !== 6'b0 || {cycles, errors} !== '0 ||
            {awaddr, awid, awlen, wdata, wstrb} !== '0) begin
            n_errors++; $display("FAIL midrun_reset_values: got busy %b awv %b wv %b cyc %0d addr %0h expected 0", busy, awvalid, wvalid, cycles, awaddr);
        end
        slave_clear();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        set_modes(0, 0, 1, 0, -1);
        b = AW'($urandom);
        start_run(b, 2, 3);
        wait_done(300, found, d);
        n_checks++;
        if (!found || errors !== 16'd0 || cycles !== 32'(last_b_edge - s_edge)) begin
            n_errors++; $display("FAIL midrun_second_run: got done %b err %0d cyc %0d expected 1 0 %0d", found, errors, cycles, last_b_edge - s_edge);
        end
        n_checks++;
        if (aw_log.size() !== 3 || w_log.size() !== 9) begin
            n_errors++; $display("FAIL midrun_counts: got %0d %0d expected 3 9", aw_log.size(), w_log.size());
        end
        for (int k = 0; k < 3 && k < aw_log.size(); k++) begin
            n_checks++;
            if (aw_log[k] !== exp_aw(b, 2, k)) begin
                n_errors++; $display("FAIL midrun_aw%0d: got %0h expected %0h", k, aw_log[k], exp_aw(b, 2, k));
            end
        end
        n_checks++;
        if (w_log.size() > 0 && w_log[0] !== exp_w(2, 0)) begin
            n_errors++; $display("FAIL midrun_w0: got %0h expected %0h", w_log[0], exp_w(2, 0));
        end
    endtask

    task automatic test_random_traffic();
        bit found; int d; logic [AW-1:0] b; int l, c, e;
        for (int it = 0; it < 4; it++) begin
            b = AW'($urandom);
            l = $urandom_range(0, 6);
            c = $urandom_range(1, 10);
            e = $urandom_range(0, c - 1);
            set_modes(1, 1, 1, 1, e);
            start_run(b, l, c);
            wait_done(3000, found, d);
            n_checks++;
            if (!found || errors !== 16'd1 || cycles !== 32'(last_b_edge - s_edge) ||
                order_viol !== 0 || stab_viol !== 0 || max_out > MO) begin
                n_errors++; $display("FAIL traffic%0d_status: got done %b err %0d cyc %0d ord %0d stab %0d max %0d expected 1 1 %0d 0 0 <=%0d",
                                     it, found, errors, cycles, order_viol, stab_viol, max_out, last_b_edge - s_edge, MO);
            end
            n_checks++;
            if (aw_log.size() !== c || w_log.size() !== c * (l + 1)) begin
                n_errors++; $display("FAIL traffic%0d_counts: got %0d %0d expected %0d %0d", it, aw_log.size(), w_log.size(), c, c * (l + 1));
            end
            for (int k = 0; k < c && k < aw_log.size(); k++) begin
                n_checks++;
                if (aw_log[k] !== exp_aw(b, l, k)) begin
                    n_errors++; $display("FAIL traffic%0d_aw%0d: got %0h expected %0h", it, k, aw_log[k], exp_aw(b, l, k));
                end
            end
            for (int j = 0; j < c * (l + 1) && j < w_log.size(); j++) begin
                n_checks++;
                if (w_log[j] !== exp_w(l, j)) begin
                    n_errors++; $display("FAIL traffic%0d_w%0d: got %0h expected %0h", it, j, w_log[j], exp_w(l, j));
                end
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        slave_clear();
        set_modes(0, 0, 1, 0, -1);
        test_reset();
        test_basic();
        test_outstanding();
        test_random_ready();
        test_slverr();
        test_zero_count();
        test_reset_midrun();
        test_random_traffic();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_perf_wr_gen.md
# axi_perf_wr_gen

AXI4 write-traffic generator for the DDR performance design. It sits directly upstream of the MIG AXI slave port, driving the `m_axi_aw*`, `m_axi_w*` and `m_axi_b*` channels under control of the `axi_perf` command logic. It issues a configurable number of INCR bursts with a deterministic data pattern and reports the elapsed cycles and write-response errors.

## Interface
- `AXI_ADDR_WIDTH`, default 28: byte address width.
- `AXI_DATA_WIDTH`, default 128: data width; must be a multiple of 32.
- `AXI_ID_WIDTH`, default 4: ID width.
- `MAX_OUTSTANDING`, default 4: maximum number of AW handshakes without a matching B response; power of two, at least 1.
- `clk`, in, 1: sole clock, MIG UI clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: single-cycle request; ignored unless idle.
- `base_addr`, in, `AXI_ADDR_WIDTH`: first byte address; low log2(STRB) bits are treated as 0.
- `burst_len`, in, 8: AXI `awlen` (beats − 1).
- `burst_count`, in, 16: number of bursts to issue.
- `busy`, out, 1: run in progress.
- `done`, out, 1: one-cycle pulse at run end.
- `cycles`, out, 32: cycles from start acceptance to the final B handshake.
- `errors`, out, 16: count of B responses with `bresp` ≠ OKAY.
- `max_latency`, out, 16: worst-case per-burst latency, AW handshake to B handshake.
- `m_axi_aw{valid,ready,addr,id,len,size,burst}`: AXI4 write address channel.
- `m_axi_w{valid,ready,data,strb,last}`: AXI4 write data channel.
- `m_axi_b{valid,ready,id,resp}`: AXI4 write response channel.

## Operation
- FSM states:
  - IDLE → RUN on `start`. Latch all config inputs and clear `cycles`, `errors` and `max_latency`.
  - IDLE → DONE on `start` with `burst_count` = 0.
  - RUN → DONE when the B count reaches `burst_count`.
  - DONE → IDLE unconditionally after one cycle.
- AW issuer:
  - Burst k uses address `base + k*(burst_len+1)*STRB`, computed modulo 2^`AXI_ADDR_WIDTH`.
  - `awid` = k[`AXI_ID_WIDTH`-1:0]; `awsize` = log2(STRB); `awburst` = INCR (2'b01).
  - `awvalid` is asserted only while `aw_sent` < `burst_count` and `aw_sent − b_recv` < `MAX_OUTSTANDING`.
- W issuer:
  - Starts burst k only after AW k has been accepted (`w_bursts` < `aw_sent`).
  - Each beat drives every 32-bit lane with the global beat index (0, 1, 2, …); `wstrb` is all ones.
  - `wlast` is asserted on beat `burst_len`.
- B handling:
  - `bready` = 1 in RUN, 0 otherwise.
  - Each handshake increments `b_recv`. `errors` increments on non-OKAY and saturates at 0xFFFF.
- `cycles` increments every RUN cycle, saturates at 0xFFFFFFFF, and holds its value in IDLE and DONE.
- 4KB boundary crossing is the caller's responsibility; bursts are not split.

## Timing
- Reset values: all valids 0, `bready` 0, `busy` 0, `done` 0, counters 0, AW/W payload outputs 0.
- `start` in cycle N: `busy` = 1 and `awvalid` = 1 in cycle N+1.
- `awvalid` and `wvalid` hold with a stable payload until ready; no combinational path from any ready to any valid.
- AW and B handshakes in the same cycle: outstanding count unchanged.
- Back-to-back W beats are supported; sustained throughput is 1 beat/cycle when `wready` is held high.
- `done` is asserted the cycle after the final B handshake; `busy` falls in the same cycle.
- `rst_n` low mid-run: all outputs return to reset values immediately. In-flight AXI transactions are abandoned; the MIG is reset by the same domain.

## Configuration
- `AXI_PERF_WR_GEN_LATENCY_EN` defined:
  - Each AW handshake pushes the free-running cycle timestamp into a FIFO of depth `MAX_OUTSTANDING`.
  - Each B handshake pops the FIFO; `max_latency` = max(`max_latency`, now − timestamp), saturating at 0xFFFF.
  - Responses are assumed in order; all IDs are issued from one master, and the MIG returns in order.
- Not defined: no FIFO is instantiated and `max_latency` is tied to 0.

## Structure
- `axi_perf_pkg` holds:
  - Constants `AXI_BURST_INCR` and `AXI_RESP_OKAY`.
  - The `wr_gen_state_t` enum (IDLE, RUN, DONE).
- The timestamp FIFO is the existing `svc_sync_fifo` sub-module, instantiated only under `AXI_PERF_WR_GEN_LATENCY_EN`. Everything else is flat in one module.

## Test plan
- `base`=0x100, `len`=3, `count`=2, readies held high → AW addresses 0x100 and 0x140; 8 W beats with data 0..7 in every lane; `wlast` on beats 3 and 7; `done` with `errors`=0.
- `count`=8, `bvalid` withheld → exactly 4 AW handshakes occur, then `awvalid` stays low until the first B is returned.
- `awready` and `wready` toggled randomly, `len`=0 → the W beat for burst k never precedes AW k; payload is stable while valid and not ready.
- B burst 1 returns SLVERR (2'b10) with `count`=3 → `errors`=1 at `done`.
- `count`=0 → `done` pulses in the cycle after `start`; no AXI valid is ever asserted; `cycles`=0.
- `rst_n` dropped mid-run, then a new `start` → all outputs return to reset values; the second run completes with fresh counters.
